// File: rtl/mcu_pkg.sv
// Shared constants for the MCU interrupt controller: source numbering and FSM encoding.
package mcu_pkg;

  localparam int IRQ_COLDBOOT = 0;
  localparam int N_SRC_DEF    = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/mcu_irq_ctrl_src.sv
// One interrupt source: edge/level event detect, pending flag and sticky overrun flag.
module irq_src_latch #(
  parameter bit EDGE     = 1'b1,
  parameter bit COLDBOOT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic ack_i,
  output logic pend_o,
  output logic ovr_o
);

  logic src_q;
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;
  logic ev;

  // The cold-boot bit has no live source; only reset ever sets it.
  always_comb begin
    ev = 1'b0;
    if (!COLDBOOT) ev = EDGE ? (src_i & ~src_q) : src_i;
    pend_d = (pend_q & ~ack_i) | ev;
    ovr_d  = (ovr_q & ~ack_i) | (ev & pend_q & ~ack_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= 1'b0;
      pend_q <= COLDBOOT;
      ovr_q  <= 1'b0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/mcu_irq_ctrl.sv
// Interrupt aggregator: per-source pending/overrun latches, enable mask, and the
// MCU interrupt-line FSM that guarantees a high gap after every acknowledge.
module mcu_irq_ctrl
  import mcu_pkg::*;
#(
  parameter int                N_SRC     = N_SRC_DEF,
  parameter logic [N_SRC-1:0]  EDGE_MASK = ~(N_SRC)'(1),
  parameter int                HOLDOFF   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_data,
  output logic [N_SRC-1:0] int_vec,
  input  logic [N_SRC-1:0] int_ack,
  output logic             int_out_n,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun
);

  localparam logic [7:0] HOLD_LD = 8'(HOLDOFF);
  localparam logic [7:0] HOLD_RL = 8'(HOLDOFF - 1);

  logic [N_SRC-1:0] mask_q;
  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             out_n_q;
  logic             req;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    irq_src_latch #(
      .EDGE     (EDGE_MASK[gi]),
      .COLDBOOT (gi == IRQ_COLDBOOT)
    ) u_src (
      .clk    (clk),
      .reset  (reset),
      .src_i  (src_in[gi]),
      .ack_i  (int_ack[gi]),
      .pend_o (pending[gi]),
      .ovr_o  (overrun[gi])
    );
  end

  assign int_vec = pending & mask_q;
  assign req     = |int_vec;

  // Reset lands in HOLD so the cold-boot interrupt is delayed by a full holdoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (|int_ack) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_RL;
        end else if (!req) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) state_d = req ? ST_ASSERT : ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= HOLD_LD;
      mask_q  <= '1;
      out_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_n_q <= (state_d != ST_ASSERT);
      if (mask_we) mask_q <= mask_data;
    end
  end

  assign int_out_n = out_n_q;

endmodule

// File: tb/tb_mcu_irq_ctrl.sv
// Directed bench for mcu_irq_ctrl: cold boot, edge/level sources, event-vs-ack race,
// masking, and reset during holdoff.
module tb_mcu_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_in;
  logic       mask_we;
  logic [7:0] mask_data;
  logic [7:0] int_vec;
  logic [7:0] int_ack;
  logic       int_out_n;
  logic [7:0] pending;
  logic [7:0] overrun;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcu_irq_ctrl #(
    .N_SRC     (8),
    .EDGE_MASK (8'hFA),
    .HOLDOFF   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_in    (src_in),
    .mask_we   (mask_we),
    .mask_data (mask_data),
    .int_vec   (int_vec),
    .int_ack   (int_ack),
    .int_out_n (int_out_n),
    .pending   (pending),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    int lo;
    reset = 1'b1; src_in = '0; mask_we = 1'b0; mask_data = '0; int_ack = '0;
    step(); step();
    check("rst_pending", pending, 8'h01);
    check("rst_overrun", overrun, 8'h00);
    check("rst_out_n", int_out_n, 1'b1);
    check("rst_int_vec", int_vec, 8'h01);
    reset = 1'b0;

    // Cold boot: 16 further high cycles, then asserted.
    hi = 0;
    for (int i = 0; i < 16; i++) begin step(); if (int_out_n) hi++; end
    check("boot_hold_cycles", hi, 16);
    step();
    check("boot_assert", int_out_n, 1'b0);
    check("boot_int_vec", int_vec, 8'h01);
    int_ack = 8'h01; step(); int_ack = '0;
    check("boot_ack_vec", int_vec, 8'h00);
    check("boot_ack_out_n", int_out_n, 1'b1);
    lo = 0;
    for (int i = 0; i < 20; i++) begin step(); if (!int_out_n) lo++; end
    check("boot_stays_high", lo, 0);
    check("boot_never_repends", pending, 8'h00);

    // Edge source held for 5 cycles yields one pending bit.
    src_in = 8'h08; step();
    check("edge_pending", pending, 8'h08);
    check("edge_out_k1", int_out_n, 1'b1);
    step();
    check("edge_out_k2", int_out_n, 1'b0);
    check("edge_int_vec", int_vec, 8'h08);
    step(); step(); step(); src_in = '0;
    check("edge_no_overrun", overrun, 8'h00);
    int_ack = 8'h08; step(); int_ack = '0;
    check("edge_ack_clear", pending, 8'h00);
    lo = 0;
    for (int i = 0; i < 20; i++) begin step(); if (!int_out_n) lo++; end
    check("edge_no_repend", pending, 8'h00);
    check("edge_stays_high", lo, 0);

    // Level source on bit 2 stays pending through its ack; holdoff is exactly 16.
    src_in = 8'h04; step();
    check("lvl_pending", pending, 8'h04);
    step();
    check("lvl_assert", int_out_n, 1'b0);
    int_ack = 8'h04; step(); int_ack = '0;
    check("lvl_after_ack", pending[2], 1'b1);
    check("lvl_hold_start", int_out_n, 1'b1);
    step();
    check("lvl_repend", pending[2], 1'b1);
    hi = 0;
    for (int i = 0; i < 14; i++) begin step(); if (int_out_n) hi++; end
    check("lvl_hold_cycles", hi, 14);
    step();
    check("lvl_reassert", int_out_n, 1'b0);
    src_in = '0; int_ack = 8'h04; step(); int_ack = '0;
    check("lvl_release_pend", pending, 8'h00);
    check("lvl_release_ovr", overrun, 8'h00);
    for (int i = 0; i < 20; i++) step();
    check("lvl_idle", int_out_n, 1'b1);

    // Event and ack on the same bit in the same cycle: the event wins.
    src_in = 8'h10; step(); src_in = '0; step();
    check("race_assert", int_out_n, 1'b0);
    src_in = 8'h10; int_ack = 8'h10; step(); src_in = '0; int_ack = '0;
    check("race_pending", pending[4], 1'b1);
    check("race_no_overrun", overrun[4], 1'b0);
    step();
    src_in = 8'h10; step(); src_in = '0;
    check("race_overrun", overrun, 8'h10);
    step();
    int_ack = 8'h10; step(); int_ack = '0;
    check("race_ack_pend", pending, 8'h00);
    check("race_ack_ovr", overrun, 8'h00);
    for (int i = 0; i < 20; i++) step();
    check("race_idle", int_out_n, 1'b1);

    // Masking a pending bit drops the request; re-enabling re-asserts 2 cycles later.
    src_in = 8'h08; step(); src_in = '0; step();
    check("mask_pre_assert", int_out_n, 1'b0);
    mask_we = 1'b1; mask_data = 8'hF7; step(); mask_we = 1'b0;
    check("mask_int_vec", int_vec, 8'h00);
    step();
    check("mask_idle", int_out_n, 1'b1);
    check("mask_pending_kept", pending, 8'h08);
    mask_we = 1'b1; mask_data = 8'hFF; step(); mask_we = 1'b0;
    check("unmask_k1", int_out_n, 1'b1);
    step();
    check("unmask_k2", int_out_n, 1'b0);

    // Reset in the middle of a holdoff restores everything and restarts it.
    int_ack = 8'h08; step(); int_ack = '0;
    src_in = 8'h20; step(); src_in = '0; step();
    src_in = 8'h20; step(); src_in = '0; step();
    for (int i = 0; i < 6; i++) step();
    check("hold_cnt", dut.cnt_q, 5);
    check("hold_pending", pending, 8'h20);
    check("hold_overrun", overrun, 8'h20);
    check("hold_out_n", int_out_n, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_pending", pending, 8'h01);
    check("mid_rst_overrun", overrun, 8'h00);
    check("mid_rst_out_n", int_out_n, 1'b1);
    hi = 0;
    for (int i = 0; i < 16; i++) begin step(); if (int_out_n) hi++; end
    check("mid_rst_hold", hi, 16);
    step();
    check("mid_rst_assert", int_out_n, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_irq_ctrl.md
Name: mcu_irq_ctrl

Overview:
Interrupt aggregator and scheduler between core event sources and the MCU system-control channel. Latches events from up to N sources into pending bits and applies a mask. Presents the pending vector to sysctrl, whose int_in/int_ack ports connect directly to this block. Drives the MCU interrupt line, forcing a guaranteed high gap after each acknowledge so the MCU always sees a fresh falling edge.

Parameters:
N_SRC, 8, number of interrupt sources; bit 0 is reserved for the cold-boot notification.
EDGE_MASK, 8'hFE, per-source mode: 1 = rising-edge triggered, 0 = level triggered.
HOLDOFF, 16, cycles that int_out_n is held high after an acknowledge; range 1..255.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
src_in  in  N_SRC  raw event inputs, synchronous to clk; src_in[0] is ignored
mask_we  in  1  one-cycle strobe that loads mask
mask_data  in  N_SRC  new enable mask; 1 = source enabled
int_vec  out  N_SRC  pending & mask; connects to sysctrl int_in
int_ack  in  N_SRC  one-cycle acknowledge vector from sysctrl int_ack
int_out_n  out  1  active-low interrupt line to the MCU
pending  out  N_SRC  raw pending register, unmasked, for debug
overrun  out  N_SRC  sticky flag per source: an event arrived while that bit was already pending

Behaviour:
- Reset: reset synchronous, active-high; clock clk. Values after reset:
  - pending = 1 (only the cold-boot bit set)
  - mask = all ones
  - overrun = 0
  - src_q (edge-detect history) = 0
  - FSM = HOLD, counter = HOLDOFF
  - int_out_n = 1
- Event detection, per bit i ≥ 1:
  - Edge mode: ev[i] = src_in[i] & ~src_q[i].
  - Level mode: ev[i] = src_in[i].
  - src_q is registered every cycle.
- Pending update, per bit, each cycle: next = (pending & ~int_ack) | ev.
  - If an event and an ack hit the same bit in the same cycle, the bit stays set; the event wins.
  - A level source still asserted after its ack re-pends on the next cycle.
- Overrun: set when ev[i] & pending[i] & ~int_ack[i]. Cleared only by int_ack[i].
- Mask:
  - mask_we loads mask on the same edge.
  - Masked bits still latch pending but do not appear in int_vec and do not drive the interrupt.
- int_vec is combinational: pending & mask, from registers only.
- FSM, with req = |(pending & mask):
  - IDLE: int_out_n = 1.
    - If req, go to ASSERT next cycle.
  - ASSERT: int_out_n = 0.
    - Any int_ack bit nonzero: go to HOLD and load counter = HOLDOFF-1.
    - Otherwise, if req drops (e.g. the bit is masked off): go to IDLE.
  - HOLD: int_out_n = 1; counter decrements each cycle.
    - At counter = 0: go to ASSERT if req, else IDLE.
    - Acks arriving during HOLD still clear bits but do not restart the counter.
- int_out_n is a registered output, decoded from the state register.
- Latency: event on src_in at edge k, then pending set at k+1, then int_out_n low at k+2 (from IDLE).
- Cold boot after reset:
  - Bit 0 is pending, but the FSM starts in HOLD, so int_out_n first goes low HOLDOFF+1 cycles after reset release.
  - Bit 0 is never set again except by reset.
- Reset mid-operation aborts HOLD/ASSERT immediately and restores all reset values.

Decomposition:
- Shared package mcu_pkg:
  - IRQ_COLDBOOT = 0
  - default N_SRC
  - FSM state encoding: IDLE = 2'd0, ASSERT = 2'd1, HOLD = 2'd2
- One natural sub-module: irq_src_latch, a single-bit edge/level detect plus pending and overrun flops, instantiated N_SRC times in a generate loop. The FSM stays in the top level.

Test Plan:
- Cold boot: release reset with src_in = 0.
  - int_out_n stays 1 for 16 cycles, then goes 0; int_vec = 8'h01.
  - int_ack = 8'h01: int_vec = 0, int_out_n = 1 from the next cycle and remains 1.
- Edge source: pulse src_in[3] for 5 cycles.
  - Exactly one pending bit; int_vec = 8'h08; int_out_n low 2 cycles after the rising edge.
  - Ack clears the bit and no re-pend occurs.
- Level source: set EDGE_MASK bit 2 = 0 and hold src_in[2] = 1, then ack bit 2.
  - pending[2] reasserts one cycle later.
  - int_out_n shows exactly HOLDOFF high cycles, then goes low again.
- Simultaneous event and ack: a rising edge on src_in[4] in the same cycle as int_ack[4] = 1.
  - pending[4] remains 1 and overrun[4] = 0.
  - A second edge before any ack sets overrun[4] = 1.
- Masking: mask_data = 8'hF7 with bit 3 pending.
  - int_vec = 0 and the FSM goes ASSERT → IDLE; pending[3] still 1.
  - Re-enable bit 3: int_out_n low 2 cycles later.
- Reset during HOLD: assert reset at counter = 5.
  - Next cycle: pending = 8'h01, overrun = 0, int_out_n = 1.
  - The full 16-cycle holdoff restarts.
